// File: rtl/if_id_fetch_buffer_if.sv
// Bus between the IF stage / instruction memory / ID stage and the
// IF/ID fetch buffer. The buffer side uses the slave modport.
interface if_id_fetch_buffer_if;
    logic [31:0] PC_in_IFID;
    logic [31:0] imem_rdata_IFID;
    logic        stall_IFID;
    logic        flush_IFID;
    logic        PC_en_IFID;
    logic        valid_IFID;
    logic [31:0] PC_out_IFID;
    logic [31:0] inst_out_IFID;

    modport master (
        output PC_in_IFID,
        output imem_rdata_IFID,
        output stall_IFID,
        output flush_IFID,
        input  PC_en_IFID,
        input  valid_IFID,
        input  PC_out_IFID,
        input  inst_out_IFID
    );

    modport slave (
        input  PC_in_IFID,
        input  imem_rdata_IFID,
        input  stall_IFID,
        input  flush_IFID,
        output PC_en_IFID,
        output valid_IFID,
        output PC_out_IFID,
        output inst_out_IFID
    );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// IF/ID fetch buffer: tracks the outstanding instruction-memory read,
// queues returned {pc, inst} pairs in order and presents one per cycle
// to ID. The PC enable is a credit check so a returning word always has
// a free slot; a flush discards everything younger than the branch.
module if_id_fetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input logic              clk_IFID,
    input logic              rst_IFID,
    if_id_fetch_buffer_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             req_v;
    logic [31:0]      req_pc;
    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_inst [DEPTH];

    logic             valid;
    logic             pop;
    logic             push;
    logic             issue;
    logic             pc_en;
    logic [CNT_W:0]   occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Handshake events and the credit-based PC enable
    always_comb begin
        valid     = (count != '0);
        pop       = valid & ~bus.stall_IFID;
        push      = req_v & ~bus.flush_IFID;
        // entries held after this edge, counting the read already in flight
        occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(req_v) - (CNT_W+1)'(pop);
        pc_en     = rst_IFID & (bus.flush_IFID | (occupancy < (CNT_W+1)'(DEPTH)));
        issue     = pc_en & ~bus.flush_IFID;
    end

    // Head-of-buffer presentation to ID, bubble when empty
    always_comb begin
        bus.PC_en_IFID    = pc_en;
        bus.valid_IFID    = valid;
        bus.PC_out_IFID   = valid ? fifo_pc[rd_ptr]   : '0;
        bus.inst_out_IFID = valid ? fifo_inst[rd_ptr] : NOP_INST;
    end

    // Control state: outstanding request, pointers and occupancy
    always_ff @(posedge clk_IFID or negedge rst_IFID) begin
        if (!rst_IFID) begin
            req_v  <= 1'b0;
            req_pc <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            req_v  <= issue;
            req_pc <= bus.PC_in_IFID;
            if (bus.flush_IFID) begin
                // dropping entries = moving the read pointer up to the write pointer
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Entry storage; contents are only observed while counted as valid
    always_ff @(posedge clk_IFID) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= bus.imem_rdata_IFID;
        end
    end

    // The credit rule must never let a returning word meet a full buffer
    a_no_overflow: assert property (
        @(posedge clk_IFID) disable iff (!rst_IFID)
        !(push && (count == CNT_W'(DEPTH)))
    );
endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Bench for the IF/ID fetch buffer: an IF PC register and synchronous
// instruction memory surround the DUT; a queue model predicts outputs.
module tb_if_id_fetch_buffer;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    if_id_fetch_buffer_if bus();

    if_id_fetch_buffer #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk_IFID (clk),
        .rst_IFID (rst_n),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h00500093 + (pc << 18);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // IF stage PC register and synchronous instruction memory
    logic [31:0] pc_reg;
    logic [31:0] target;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= '0;
        else if (bus.PC_en_IFID) pc_reg <= bus.flush_IFID ? target : pc_reg + 32'd4;
    end
    always @(posedge clk) bus.imem_rdata_IFID <= inst_of(pc_reg);
    always_comb bus.PC_in_IFID = pc_reg;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: in-order queue of fetched {pc,inst} plus one in-flight read
    logic [63:0] mq[$];
    logic        m_inflight = 1'b0;
    logic [31:0] m_inflight_pc = '0;
    logic        m_valid, m_pop, m_pc_en;
    logic [31:0] pops[$];
    int unsigned pop_cyc[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 32'(bus.valid_IFID), 32'd0);
            check("rst_pc_out", bus.PC_out_IFID, 32'd0);
            check("rst_inst", bus.inst_out_IFID, NOP);
            check("rst_pc_en", 32'(bus.PC_en_IFID), 32'd0);
            mq.delete();
            m_inflight = 1'b0;
        end else begin
            m_valid = (mq.size() != 0);
            m_pop   = m_valid && !bus.stall_IFID;
            m_pc_en = bus.flush_IFID ||
                      (int'(mq.size()) + int'(m_inflight) - int'(m_pop) < int'(DEPTH));
            check("valid", 32'(bus.valid_IFID), 32'(m_valid));
            check("pc_out", bus.PC_out_IFID, m_valid ? mq[0][63:32] : 32'd0);
            check("inst_out", bus.inst_out_IFID, m_valid ? mq[0][31:0] : NOP);
            check("pc_en", 32'(bus.PC_en_IFID), 32'(m_pc_en));
            if (bus.valid_IFID && !bus.stall_IFID && !bus.flush_IFID) begin
                pops.push_back(bus.PC_out_IFID);
                pop_cyc.push_back(cyc);
            end
            if (bus.flush_IFID) begin
                mq.delete();
                m_inflight = 1'b0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_inflight) mq.push_back({m_inflight_pc, inst_of(m_inflight_pc)});
                m_inflight    = m_pc_en;
                m_inflight_pc = bus.PC_in_IFID;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic found;
        bus.stall_IFID = 1'b0;
        bus.flush_IFID = 1'b0;
        target = '0;
        #1 rst_n = 1'b0;

        // reset and first fetch
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); check("pc_en_after_release", 32'(bus.PC_en_IFID), 32'd1);
        @(negedge clk); check("first_latency_valid0", 32'(bus.valid_IFID), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(bus.valid_IFID), 32'd1);
        check("first_pc", bus.PC_out_IFID, 32'h0);
        check("first_inst", bus.inst_out_IFID, 32'h00500093);

        // streaming 0x00..0x3C back to back
        for (int i = 0; i < 40 && pops.size() < 16; i++) @(posedge clk);
        check("stream_count_ok", 32'(pops.size() >= 16), 32'd1);
        if (pops.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                check("stream_pc", pops[i], 32'(4 * i));
                check("stream_cycle", pop_cyc[i] - pop_cyc[0], 32'(i));
            end
        end

        // asynchronous reset mid-stream
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.valid_IFID), 32'd0);
        check("async_inst", bus.inst_out_IFID, NOP);
        check("async_pc_en", 32'(bus.PC_en_IFID), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); check("post_rst_valid_a", 32'(bus.valid_IFID), 32'd0);
        @(negedge clk); check("post_rst_valid_b", 32'(bus.valid_IFID), 32'd0);
        @(negedge clk);
        check("post_rst_valid_c", 32'(bus.valid_IFID), 32'd1);
        check("post_rst_pc", bus.PC_out_IFID, 32'h0);

        // stall four cycles while 0x10 is at ID
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.valid_IFID && bus.PC_out_IFID == 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        check("stall_head_found", 32'(found), 32'd1);
        bus.stall_IFID = 1'b1;
        n = pops.size();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_pc_en", 32'(bus.PC_en_IFID), 32'd0);
        check("stall_count", 32'(dut.count), 32'd2);
        @(posedge clk); #1 bus.stall_IFID = 1'b0;
        for (int i = 0; i < 20 && pops.size() < n + 3; i++) @(posedge clk);
        check("stall_resume_count_ok", 32'(pops.size() >= n + 3), 32'd1);
        if (pops.size() >= n + 3) begin
            check("resume_pc0", pops[n],     32'h10);
            check("resume_pc1", pops[n + 1], 32'h14);
            check("resume_pc2", pops[n + 2], 32'h18);
        end

        // flush mid-stream to 0x100
        repeat (3) @(posedge clk);
        #1;
        bus.flush_IFID = 1'b1;
        target = 32'h100;
        n = pops.size();
        @(negedge clk); check("flush_pc_en", 32'(bus.PC_en_IFID), 32'd1);
        @(posedge clk); #1 bus.flush_IFID = 1'b0;
        @(negedge clk); check("flush_t1_valid", 32'(bus.valid_IFID), 32'd0);
        @(negedge clk); check("flush_t2_valid", 32'(bus.valid_IFID), 32'd0);
        @(negedge clk);
        check("flush_t3_valid", 32'(bus.valid_IFID), 32'd1);
        check("flush_t3_pc", bus.PC_out_IFID, 32'h100);
        check("flush_t3_inst", bus.inst_out_IFID, 32'h04500093);
        @(posedge clk);
        check("flush_first_pop_ok", 32'(pops.size() > n), 32'd1);
        if (pops.size() > n) check("flush_first_pop", pops[n], 32'h100);

        // flush together with stall on a full buffer
        repeat (2) @(posedge clk);
        #1 bus.stall_IFID = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.flush_IFID = 1'b1;
        target = 32'h200;
        @(negedge clk);
        check("fs_full_count", 32'(dut.count), 32'd2);
        check("fs_pc_en", 32'(bus.PC_en_IFID), 32'd1);
        @(posedge clk); #1;
        bus.flush_IFID = 1'b0;
        bus.stall_IFID = 1'b0;
        @(negedge clk);
        check("fs_t1_valid", 32'(bus.valid_IFID), 32'd0);
        check("fs_t1_count", 32'(dut.count), 32'd0);
        @(negedge clk); check("fs_t2_valid", 32'(bus.valid_IFID), 32'd0);
        @(negedge clk);
        check("fs_t3_valid", 32'(bus.valid_IFID), 32'd1);
        check("fs_t3_pc", bus.PC_out_IFID, 32'h200);
        check("fs_t3_inst", bus.inst_out_IFID, 32'h08500093);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
